arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised registered N-channel data selector with valid/ready handshakes and selectable arbitration mode. It is the pipelined successor to the combinational word multiplexers in the datapath. It merges NCH producers, for example writeback or memory-port requesters, onto one WIDTH-bit output stage. Channel choice comes from fixed priority, round-robin, or an externally driven select.

## Interface
- WIDTH, 32, data width per channel (1..64)
- NCH, 4, channel count; power of two, 2..16
- SELW, $clog2(NCH), channel-index width (derived; do not override)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  00 fixed priority, 01 round-robin, 10 external select, 11 treated as 00
- sel  in  SELW  channel index used in mode 10
- in_data  in  NCH*WIDTH  packed inputs; channel j is bits [j*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel request
- in_ready  out  NCH  per-channel accept (combinational)
- out_data  out  WIDTH  registered selected data
- out_ch  out  SELW  registered index of the channel that supplied out_data
- out_valid  out  1  output holds a word
- out_ready  in  1  consumer accepts the output word

## Operation
- Single output register stage. Define can_accept = !out_valid || out_ready.
- Winner selection, combinational, evaluated each cycle:
  - mode 00: lowest-index j with in_valid[j]=1.
  - mode 01: first j with in_valid[j]=1, searching from (ptr+1) mod NCH upward with wrap.
  - mode 10: winner = sel if in_valid[sel]=1; otherwise no winner, even if other channels are valid.
- in_ready[w]=1 only for winner w, and only when can_accept=1 and reset=0. All other in_ready bits are 0. At most one in_ready bit is ever high.
- Transfer on input side (channel w): in_valid[w] && in_ready[w]. At the clock edge:
  - out_data <= in_data[w]
  - out_ch <= w
  - out_valid <= 1
  - ptr <= w, in every mode, so round-robin resumes after the last grantee.
- No input transfer and out_ready=1: out_valid <= 0. out_data and out_ch hold their values.
- out_valid=1 and out_ready=0: out_data, out_ch and out_valid hold; all in_ready bits are 0 (stall).
- ptr is a SELW-bit internal register; it changes only on input transfers.
- A mode or sel change takes effect in the same cycle's combinational selection. No internal state beyond ptr and the output stage.

## Timing
- Reset, asserted asynchronously:
  - out_valid=0, out_data=0, out_ch=0, ptr=NCH-1, so channel 0 wins first in round-robin.
  - in_ready=0 throughout reset.
- Reset mid-transfer: the held word is discarded. No transfer is recorded for the cycle in which reset is high.
- Latency: an input accepted at edge k appears on out_data/out_valid immediately after edge k.
- Throughput: one word per cycle while out_ready=1 and any eligible request exists.
- Simultaneous out-side and in-side handshake in one cycle: the new word replaces the old one. out_valid stays 1, with no bubble.
- Round-robin wrap: ptr=NCH-1 searches 0,1,…,NCH-1 in that order.
- Single requester in mode 01: that channel is granted every cycle.
- out_ready may be low indefinitely; data and out_ch must remain stable while out_valid=1 and out_ready=0.

## Test plan
- Reset, then release, NCH=4, WIDTH=32, mode 00, in_valid=4'b1010, out_ready=1:
  - required: in_ready=4'b0010, then out_data=in_data ch1, out_ch=1, out_valid=1 one cycle later.
- Mode 01, all four valid continuously, out_ready=1:
  - required: out_ch sequence 0,1,2,3,0,1, one word per cycle.
  - then drop in_valid[1]: required sequence skips 1 (…,0,2,3,0).
- Mode 10, sel=2, in_valid=4'b0011:
  - required: no grant, in_ready=0, out_valid falls to 0.
  - then set in_valid[2]=1 with in_data ch2=32'hDEADBEEF: required out_data=32'hDEADBEEF, out_ch=2.
- Backpressure: out_valid=1, hold out_ready=0 for 5 cycles with all inputs valid.
  - required: out_data and out_ch stable, in_ready=0 throughout.
  - then out_ready=1: new grant in the same cycle, no bubble.
- Assert reset asynchronously mid-stream (between edges) while out_valid=1:
  - required: out_valid=0, out_data=0 immediately.
  - after release in mode 01 with all channels valid: first grant goes to channel 0.
- Parameter sweep NCH=2 and NCH=16, WIDTH=8:
  - required: round-robin wraps at NCH-1→0.
  - required: in_ready is one-hot or zero every cycle.

Source files
------------

// File: rtl/arb_mux_if.sv
// Handshake bundle between NCH producers, the arb_mux output stage and its consumer.
// The slave modport is the mux's view; master is the view of whoever drives it.
interface arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic [1:0]           mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/arb_mux.sv
// Registered NCH:1 word selector: fixed-priority, round-robin or external-select arbitration.
// Latency: a word granted at edge k is on out_data/out_valid right after edge k.
// Backpressure: in_ready is held low while out_valid=1 and out_ready=0; output word stays stable.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    arb_mux_if.slave   bus
);
    localparam int SELW = $clog2(NCH);

    typedef enum logic [1:0] {
        MODE_PRIO = 2'b00,
        MODE_RR   = 2'b01,
        MODE_EXT  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  win;
    logic             win_vld;
    logic [SELW-1:0]  rr_idx;
    logic             can_accept;
    logic             grant;
    logic [WIDTH-1:0] win_dat;
    logic [NCH-1:0]   ready_vec;

    // Winner selection; no state other than ptr feeds it.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        rr_idx  = '0;
        unique case (mode_e'(bus.mode))
            MODE_RR: begin
                // NCH is a power of two, so SELW-bit addition wraps modulo NCH;
                // k=NCH lands back on ptr itself, last in the search order.
                for (int k = 1; k <= NCH; k++) begin
                    rr_idx = ptr + SELW'(k);
                    if (!win_vld && bus.in_valid[rr_idx]) begin
                        win     = rr_idx;
                        win_vld = 1'b1;
                    end
                end
            end
            MODE_EXT: begin
                win     = bus.sel;
                win_vld = bus.in_valid[bus.sel];
            end
            MODE_PRIO, MODE_RSVD: begin
                for (int j = NCH - 1; j >= 0; j--) begin
                    if (bus.in_valid[j]) begin
                        win     = SELW'(j);
                        win_vld = 1'b1;
                    end
                end
            end
            default: begin
                win     = '0;
                win_vld = 1'b0;
            end
        endcase
    end

    assign can_accept = !bus.out_valid || bus.out_ready;
    assign grant      = win_vld && can_accept && !reset;

    always_comb begin
        ready_vec      = '0;
        ready_vec[win] = grant;
    end
    assign bus.in_ready = ready_vec;

    always_comb begin
        win_dat = '0;
        for (int j = 0; j < NCH; j++) begin
            if (win == SELW'(j)) begin
                win_dat = bus.in_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // ptr starts at NCH-1 so the first round-robin search begins at channel 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= SELW'(NCH - 1);
        end else if (grant) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= win_dat;
            bus.out_ch    <= win;
            ptr           <= win;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.in_ready));

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_ch)));

    a_stall_no_ready: assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready) |-> (bus.in_ready == '0));
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4x32 instance for the main scenarios plus 2x8 and 16x8 for wrap.
module tb_arb_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(32), .NCH(4))  b4 ();
    arb_mux_if #(.WIDTH(8),  .NCH(2))  b2 ();
    arb_mux_if #(.WIDTH(8),  .NCH(16)) b16 ();

    arb_mux #(.WIDTH(32), .NCH(4))  u4  (.clk(clk), .reset(rst), .bus(b4));
    arb_mux #(.WIDTH(8),  .NCH(2))  u2  (.clk(clk), .reset(rst), .bus(b2));
    arb_mux #(.WIDTH(8),  .NCH(16)) u16 (.clk(clk), .reset(rst), .bus(b16));

    function automatic logic [31:0] w4(input int j);
        return 32'hC0DE_0000 | 32'(j);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b4.mode = 2'b00; b4.sel = '0; b4.out_ready = 1'b1; b4.in_valid = 4'b1010;
        for (int j = 0; j < 4; j++) b4.in_data[j*32 +: 32] = w4(j);
        b2.mode = 2'b01; b2.sel = '0; b2.out_ready = 1'b1; b2.in_valid = '0;
        b16.mode = 2'b01; b16.sel = '0; b16.out_ready = 1'b1; b16.in_valid = '0;
        for (int j = 0; j < 2; j++)  b2.in_data[j*8 +: 8] = 8'h5A ^ 8'(j);
        for (int j = 0; j < 16; j++) b16.in_data[j*8 +: 8] = 8'(j * 17);
        #1;
        checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got %b exp 0000", b4.in_ready); end
        checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", b4.out_valid); end
        checks++; if (b4.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", b4.out_data); end
        checks++; if (b4.out_ch !== 2'd0) begin errors++; $display("FAIL rst_out_ch got %0d exp 0", b4.out_ch); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (b4.in_ready !== 4'b0010) begin errors++; $display("FAIL prio_in_ready got %b exp 0010", b4.in_ready); end
        step();
        checks++; if (b4.out_data !== w4(1)) begin errors++; $display("FAIL prio_data got %h exp %h", b4.out_data, w4(1)); end
        checks++; if (b4.out_ch !== 2'd1) begin errors++; $display("FAIL prio_ch got %0d exp 1", b4.out_ch); end
        checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %b exp 1", b4.out_valid); end
    endtask

    task automatic test_round_robin();
        int exp_a[6] = '{0, 1, 2, 3, 0, 1};
        int exp_b[4] = '{2, 3, 0, 2};
        rst = 1'b1; #1; rst = 1'b0;
        b4.mode = 2'b01; b4.in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (b4.out_ch !== 2'(exp_a[i]) || b4.out_valid !== 1'b1) begin errors++; $display("FAIL rr_seq[%0d] got ch %0d v %b exp ch %0d v 1", i, b4.out_ch, b4.out_valid, exp_a[i]); end
            checks++; if (b4.out_data !== w4(exp_a[i])) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, b4.out_data, w4(exp_a[i])); end
        end
        b4.in_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (b4.out_ch !== 2'(exp_b[i]) || b4.out_valid !== 1'b1) begin errors++; $display("FAIL rr_skip[%0d] got ch %0d v %b exp ch %0d v 1", i, b4.out_ch, b4.out_valid, exp_b[i]); end
        end
    endtask

    task automatic test_ext_select();
        b4.mode = 2'b10; b4.sel = 2'd2; b4.in_valid = 4'b0011;
        #1;
        checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL ext_nogrant_ready got %b exp 0000", b4.in_ready); end
        step();
        checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL ext_drain_valid got %b exp 0", b4.out_valid); end
        b4.in_valid = 4'b0111;
        b4.in_data[2*32 +: 32] = 32'hDEADBEEF;
        #1;
        checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL ext_ready got %b exp 0100", b4.in_ready); end
        step();
        checks++; if (b4.out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ext_data got %h exp deadbeef", b4.out_data); end
        checks++; if (b4.out_ch !== 2'd2 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL ext_ch got ch %0d v %b exp ch 2 v 1", b4.out_ch, b4.out_valid); end
    endtask

    task automatic test_backpressure();
        b4.mode = 2'b01; b4.in_valid = 4'b1111; b4.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, b4.in_ready); end
            step();
            checks++; if (b4.out_data !== 32'hDEADBEEF || b4.out_ch !== 2'd2 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %h ch %0d v %b exp deadbeef ch 2 v 1", i, b4.out_data, b4.out_ch, b4.out_valid); end
        end
        b4.out_ready = 1'b1;
        b4.in_data[2*32 +: 32] = w4(2);
        #1;
        checks++; if (b4.in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", b4.in_ready); end
        step();
        checks++; if (b4.out_ch !== 2'd3 || b4.out_valid !== 1'b1 || b4.out_data !== w4(3)) begin errors++; $display("FAIL bp_release got %h ch %0d v %b exp %h ch 3 v 1", b4.out_data, b4.out_ch, b4.out_valid, w4(3)); end
    endtask

    task automatic test_async_reset();
        step();
        checks++; if (b4.out_ch !== 2'd0 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre0 got ch %0d v %b exp ch 0 v 1", b4.out_ch, b4.out_valid); end
        step();
        checks++; if (b4.out_ch !== 2'd1 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre1 got ch %0d v %b exp ch 1 v 1", b4.out_ch, b4.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 32'h0 || b4.out_ch !== 2'd0) begin errors++; $display("FAIL ar_clear got %h ch %0d v %b exp 0 ch 0 v 0", b4.out_data, b4.out_ch, b4.out_valid); end
        checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL ar_ready got %b exp 0000", b4.in_ready); end
        step();
        checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL ar_held got v %b exp 0", b4.out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_ready got %b exp 0001", b4.in_ready); end
        step();
        checks++; if (b4.out_ch !== 2'd0 || b4.out_data !== w4(0) || b4.out_valid !== 1'b1) begin errors++; $display("FAIL ar_first got %h ch %0d v %b exp %h ch 0 v 1", b4.out_data, b4.out_ch, b4.out_valid, w4(0)); end
    endtask

    task automatic test_sweep();
        int exp16[3] = '{15, 0, 15};
        b2.in_valid = 2'b11;
        b16.in_valid = 16'hFFFF;
        for (int i = 0; i < 18; i++) begin
            #1;
            checks++; if (b16.in_ready !== (16'h1 << (i % 16))) begin errors++; $display("FAIL sw16_ready[%0d] got %h exp %h", i, b16.in_ready, 16'h1 << (i % 16)); end
            checks++; if ($onehot0(b2.in_ready) !== 1'b1 || b2.in_ready === 2'b00) begin errors++; $display("FAIL sw2_ready[%0d] got %b exp one-hot", i, b2.in_ready); end
            step();
            checks++; if (b16.out_ch !== 4'(i % 16) || b16.out_data !== 8'((i % 16) * 17)) begin errors++; $display("FAIL sw16_out[%0d] got ch %0d d %h exp ch %0d d %h", i, b16.out_ch, b16.out_data, i % 16, 8'((i % 16) * 17)); end
            checks++; if (b2.out_ch !== 1'(i % 2) || b2.out_data !== (8'h5A ^ 8'(i % 2))) begin errors++; $display("FAIL sw2_out[%0d] got ch %0d d %h exp ch %0d", i, b2.out_ch, b2.out_data, i % 2); end
        end
        b16.in_valid = 16'h8001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b16.in_ready !== (16'h1 << exp16[i])) begin errors++; $display("FAIL sw16_wrap_ready[%0d] got %h exp %h", i, b16.in_ready, 16'h1 << exp16[i]); end
            step();
            checks++; if (b16.out_ch !== 4'(exp16[i])) begin errors++; $display("FAIL sw16_wrap[%0d] got ch %0d exp %0d", i, b16.out_ch, exp16[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ext_select();
        test_backpressure();
        test_async_reset();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
